// File: rtl/e_mem_loader_if.sv
// e_mem_loader_if: exponent word stream plus the single-port RAM port
// that sit between the exponent loader and its surroundings.
interface e_mem_loader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  mem_wren;
    logic [DATA_WIDTH-1:0] mem_q;

    modport master (
        input  in_data,
        input  in_valid,
        input  mem_q,
        output in_ready,
        output mem_address,
        output mem_data,
        output mem_wren
    );

    modport slave (
        output in_data,
        output in_valid,
        output mem_q,
        input  in_ready,
        input  mem_address,
        input  mem_data,
        input  mem_wren
    );
endinterface

// File: rtl/e_mem_loader.sv
// e_mem_loader: streams an exponent into RAM, reads it back and checks
// the modular word sum before the ModExp core is allowed to use it.
module e_mem_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7,
    parameter int TOTAL_ADDR = 128,
    parameter int RD_LATENCY = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    e_mem_loader_if.master        bus,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [DATA_WIDTH-1:0] checksum
);
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] LAST = CW'(TOTAL_ADDR - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] WRITE = 3'd1;
    localparam logic [2:0] TURN  = 3'd2;
    localparam logic [2:0] READ  = 3'd3;
    localparam logic [2:0] DRAIN = 3'd4;
    localparam logic [2:0] CHECK = 3'd5;
    localparam logic [2:0] DONE  = 3'd6;

    logic [2:0]            state;
    logic [CW-1:0]         wr_cnt;
    logic [CW-1:0]         rd_cnt;
    logic [DATA_WIDTH-1:0] rd_sum;
    logic [RD_LATENCY:0]   tag;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wren;
    logic                  xfer;
    logic                  launch;
    logic                  pipe_clear;

    assign bus.in_ready    = (state == WRITE);
    assign bus.mem_address = address;
    assign bus.mem_data    = wdata;
    assign bus.mem_wren    = wren;

    assign busy       = (state != IDLE) && (state != DONE);
    assign xfer       = bus.in_valid && (state == WRITE);
    assign launch     = (state == TURN) || (state == READ);
    // Empty after this edge: only the oldest tag may still be set.
    assign pipe_clear = (tag[RD_LATENCY-1:0] == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            rd_sum   <= '0;
            tag      <= '0;
            address  <= '0;
            wdata    <= '0;
            wren     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            checksum <= '0;
        end else begin
            tag <= {tag[RD_LATENCY-1:0], launch};
            if (tag[RD_LATENCY])
                rd_sum <= rd_sum + bus.mem_q;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= WRITE;
                        wr_cnt   <= '0;
                        rd_cnt   <= '0;
                        checksum <= '0;
                        rd_sum   <= '0;
                        done     <= 1'b0;
                        error    <= 1'b0;
                    end
                end
                WRITE: begin
                    if (xfer) begin
                        address  <= wr_cnt[ADDR_WIDTH-1:0];
                        wdata    <= bus.in_data;
                        wren     <= 1'b1;
                        checksum <= checksum + bus.in_data;
                        wr_cnt   <= wr_cnt + CW'(1);
                        if (wr_cnt == LAST)
                            state <= TURN;
                    end else begin
                        wren <= 1'b0;
                    end
                end
                TURN: begin
                    wren    <= 1'b0;
                    address <= '0;
                    rd_cnt  <= CW'(1);
                    state   <= (TOTAL_ADDR == 1) ? DRAIN : READ;
                end
                READ: begin
                    address <= rd_cnt[ADDR_WIDTH-1:0];
                    rd_cnt  <= rd_cnt + CW'(1);
                    if (rd_cnt == LAST)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (pipe_clear)
                        state <= CHECK;
                end
                CHECK: begin
                    error <= (rd_sum != checksum);
                    done  <= 1'b1;
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
